// File: rtl/ex_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_reg
// EX->MEM pipeline register built as a two-entry elastic buffer: a main entry
// that drives the MEM-side outputs and a skid entry that catches one extra
// bundle while MEM stalls. This keeps full throughput with a registered
// in_ready. It also provides a synchronous flush, suppresses writes to r0 and
// exposes an EX->ID bypass tap taken from the head entry.
//
// Optional feature: define EX_MEM_PERF_EN to add perf_stall_cnt, a saturating
// count of cycles where the head is valid but MEM is not ready.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush            discard every buffered entry at the next edge
//   in_valid/ready   EX-side handshake (in_ready comes straight from a flop)
//   in_*             EX bundle: inst, pc, ex_result, rd_wr_addr, rd_wr_en,
//                    lsu_data, lsu_op
//   out_valid/ready  MEM-side handshake
//   out_*            head bundle
//   fwd_valid/addr/data  bypass tap: head is a non-load register write
//   perf_stall_cnt   (EX_MEM_PERF_EN only) stall cycle counter
// ---------------------------------------------------------------------------
module ex_mem_pipe_reg #(
  parameter int INST_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int REG_WIDTH    = 5,
  parameter int LSU_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INST_WIDTH-1:0]   in_inst,
  input  logic [ADDR_WIDTH-1:0]   in_pc,
  input  logic [DATA_WIDTH-1:0]   in_ex_result,
  input  logic [REG_WIDTH-1:0]    in_rd_wr_addr,
  input  logic                    in_rd_wr_en,
  input  logic [DATA_WIDTH-1:0]   in_lsu_data,
  input  logic [LSU_OP_WIDTH-1:0] in_lsu_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INST_WIDTH-1:0]   out_inst,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [DATA_WIDTH-1:0]   out_ex_result,
  output logic [REG_WIDTH-1:0]    out_rd_wr_addr,
  output logic                    out_rd_wr_en,
  output logic [DATA_WIDTH-1:0]   out_lsu_data,
  output logic [LSU_OP_WIDTH-1:0] out_lsu_op,
  output logic                    fwd_valid,
  output logic [REG_WIDTH-1:0]    fwd_addr,
`ifdef EX_MEM_PERF_EN
  output logic [31:0]             perf_stall_cnt,
`endif
  output logic [DATA_WIDTH-1:0]   fwd_data
);

  localparam int BUNDLE_W = INST_WIDTH + ADDR_WIDTH + 2 * DATA_WIDTH
                          + REG_WIDTH + 1 + LSU_OP_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                occ;
  logic [BUNDLE_W-1:0] main_q;
  logic [BUNDLE_W-1:0] skid_q;
  logic [BUNDLE_W-1:0] in_bundle;
  logic                in_wr_en_eff;
  logic                accept;
  logic                pop;

  // r0 is hardwired to zero, so a write to it is dropped before it is stored;
  // everything downstream (MEM, WB, bypass) then sees a plain non-write.
  assign in_wr_en_eff = in_rd_wr_en && (in_rd_wr_addr != '0);

  // The bundle travels as one flat vector so both entries share one layout.
  assign in_bundle = {in_inst, in_pc, in_ex_result, in_rd_wr_addr,
                      in_wr_en_eff, in_lsu_data, in_lsu_op};

  assign {out_inst, out_pc, out_ex_result, out_rd_wr_addr,
          out_rd_wr_en, out_lsu_data, out_lsu_op} = main_q;

  assign out_valid = (occ != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Loads are excluded from forwarding: their ex_result is only the address.
  assign fwd_valid = out_valid && out_rd_wr_en && (out_lsu_op == '0);
  assign fwd_addr  = out_rd_wr_addr;
  assign fwd_data  = out_ex_result;

  // Occupancy FSM plus the two data entries. in_ready is updated together
  // with the state so that it always equals (occ != TWO) without a
  // combinational path from out_ready. The skid entry only ever fills from
  // ONE with a stalled head, and drains into main on the next pop, which
  // keeps strict FIFO order. Flush only resets occupancy; the data flops are
  // left holding stale contents because out_valid masks them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= EMPTY;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      occ      <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (occ)
        EMPTY: begin
          if (accept) begin
            main_q <= in_bundle;
            occ    <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= in_bundle;
          end else if (accept) begin
            skid_q   <= in_bundle;
            occ      <= TWO;
            in_ready <= 1'b0;
          end else if (pop) begin
            occ <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_q   <= skid_q;
            occ      <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          occ      <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef EX_MEM_PERF_EN
  // Stall counter: counts cycles where MEM holds off a valid head. It
  // saturates instead of wrapping and deliberately survives flush so that
  // long-running measurements are not disturbed by branch recoveries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_pipe_reg
// Self-checking bench for ex_mem_pipe_reg. A queue of bundles models the
// buffer as an ordered FIFO of capacity two; expected outputs are derived
// from the head of that queue. Directed steps cover reset, single pass,
// backpressure, full throughput, r0/load rules, flush and async reset, then
// a randomized phase exercises mixed traffic. With EX_MEM_PERF_EN defined
// the stall counter is also checked.
// ---------------------------------------------------------------------------
module tb_ex_mem_pipe_reg;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        en;
    logic [31:0] ldata;
    logic [3:0]  op;
  } bundle_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_ex_result;
  logic [4:0]  in_rd_wr_addr;
  logic        in_rd_wr_en;
  logic [31:0] in_lsu_data;
  logic [3:0]  in_lsu_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_ex_result;
  logic [4:0]  out_rd_wr_addr;
  logic        out_rd_wr_en;
  logic [31:0] out_lsu_data;
  logic [3:0]  out_lsu_op;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_stall_cnt;
  int unsigned perf_exp;
  int unsigned perf_base;
`endif

  int checks;
  int failures;
  bundle_t model_q[$];

  ex_mem_pipe_reg dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_inst        (in_inst),
    .in_pc          (in_pc),
    .in_ex_result   (in_ex_result),
    .in_rd_wr_addr  (in_rd_wr_addr),
    .in_rd_wr_en    (in_rd_wr_en),
    .in_lsu_data    (in_lsu_data),
    .in_lsu_op      (in_lsu_op),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_ex_result  (out_ex_result),
    .out_rd_wr_addr (out_rd_wr_addr),
    .out_rd_wr_en   (out_rd_wr_en),
    .out_lsu_data   (out_lsu_data),
    .out_lsu_op     (out_lsu_op),
    .fwd_valid      (fwd_valid),
    .fwd_addr       (fwd_addr),
`ifdef EX_MEM_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .fwd_data       (fwd_data)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] res,
                               input logic [4:0] rd, input logic en, input logic [3:0] op,
                               input logic rdy, input logic fl);
    in_valid      = v;
    in_pc         = pc;
    in_ex_result  = res;
    in_rd_wr_addr = rd;
    in_rd_wr_en   = en;
    in_lsu_op     = op;
    in_inst       = $urandom;
    in_lsu_data   = $urandom;
    out_ready     = rdy;
    flush         = fl;
  endtask

  // Compare every observable output against the head of the model queue.
  task automatic checkOutput(input string tag);
    bundle_t h;
    logic    exp_en;
    chk({tag, ".out_valid"}, out_valid, model_q.size() > 0);
    chk({tag, ".in_ready"},  in_ready,  model_q.size() < 2);
    if (model_q.size() > 0) begin
      h = model_q[0];
      exp_en = h.en && (h.rd != 5'd0);
      chk({tag, ".out_inst"},      out_inst,       h.inst);
      chk({tag, ".out_pc"},        out_pc,         h.pc);
      chk({tag, ".out_ex_result"}, out_ex_result,  h.res);
      chk({tag, ".out_rd"},        out_rd_wr_addr, h.rd);
      chk({tag, ".out_rd_wr_en"},  out_rd_wr_en,   exp_en);
      chk({tag, ".out_lsu_data"},  out_lsu_data,   h.ldata);
      chk({tag, ".out_lsu_op"},    out_lsu_op,     h.op);
      chk({tag, ".fwd_valid"},     fwd_valid,      exp_en && (h.op == 4'd0));
      chk({tag, ".fwd_addr"},      fwd_addr,       h.rd);
      chk({tag, ".fwd_data"},      fwd_data,       h.res);
    end else begin
      chk({tag, ".fwd_valid"}, fwd_valid, 1'b0);
    end
`ifdef EX_MEM_PERF_EN
    chk({tag, ".perf"}, perf_stall_cnt, perf_exp);
`endif
  endtask

  // One clock: update the model from the inputs seen at the edge, then check
  // at the following falling edge.
  task automatic step(input string tag);
    bit      acc;
    bit      pp;
    bundle_t b;
    @(posedge clk);
    acc = in_valid && (model_q.size() < 2);
    pp  = (model_q.size() > 0) && out_ready;
`ifdef EX_MEM_PERF_EN
    if ((model_q.size() > 0) && !out_ready && perf_exp != 32'hFFFF_FFFF) perf_exp++;
`endif
    if (flush) begin
      model_q.delete();
    end else begin
      b.inst = in_inst; b.pc = in_pc; b.res = in_ex_result; b.rd = in_rd_wr_addr;
      b.en = in_rd_wr_en; b.ldata = in_lsu_data; b.op = in_lsu_op;
      if (pp) void'(model_q.pop_front());
      if (acc) model_q.push_back(b);
    end
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef EX_MEM_PERF_EN
    perf_exp = 0;
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.in_ready",  in_ready,  1'b1);
    chk("rst.fwd_valid", fwd_valid, 1'b0);
    chk("rst.out_pc",    out_pc,    32'd0);
    chk("rst.out_res",   out_ex_result, 32'd0);
    chk("rst.out_en",    out_rd_wr_en,  1'b0);
    checkOutput("rst");

    // Single pass
    applyStimulus(1, 32'h1C00_0000, 32'h1234_5678, 5'd4, 1, 4'd0, 1, 0);
    step("single");
    chk("single.out_valid", out_valid, 1'b1);
    chk("single.out_pc",    out_pc,    32'h1C00_0000);
    chk("single.fwd_valid", fwd_valid, 1'b1);
    chk("single.fwd_addr",  fwd_addr,  5'd4);
    chk("single.fwd_data",  fwd_data,  32'h1234_5678);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    step("single_drain");
    chk("single_drain.out_valid", out_valid, 1'b0);

    // Backpressure
    applyStimulus(1, 32'h100, 32'hA, 5'd1, 1, 0, 0, 0);
    step("bp0");
    applyStimulus(1, 32'h104, 32'hB, 5'd2, 1, 0, 0, 0);
    step("bp1");
    chk("bp.in_ready_low", in_ready, 1'b0);
    chk("bp.head_hold",    out_pc,   32'h100);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step("bp_hold");
    chk("bp.head_stable", out_pc, 32'h100);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    step("bp_pop0");
    chk("bp.second_pc",   out_pc,   32'h104);
    chk("bp.in_ready_up", in_ready, 1'b1);
    step("bp_pop1");
    chk("bp.empty", out_valid, 1'b0);

    // Full throughput
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 32'(i * 4), $urandom, 5'(i + 1), 1, 0, 1, 0);
      step("thru");
      chk("thru.pc",       out_pc,   32'(i * 4));
      chk("thru.in_ready", in_ready, 1'b1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    step("thru_drain");

    // r0 suppression and load non-forwarding
    applyStimulus(1, 32'h200, 32'h55, 5'd0, 1, 4'd0, 1, 0);
    step("r0");
    chk("r0.en",  out_rd_wr_en, 1'b0);
    chk("r0.fwd", fwd_valid,    1'b0);
    applyStimulus(1, 32'h204, 32'h66, 5'd7, 1, 4'd2, 1, 0);
    step("load");
    chk("load.en",  out_rd_wr_en, 1'b1);
    chk("load.fwd", fwd_valid,    1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    step("load_drain");

    // Flush with a full buffer and a simultaneous valid input
    applyStimulus(1, 32'h300, 1, 5'd3, 1, 0, 0, 0);
    step("fl_fill0");
    applyStimulus(1, 32'h304, 2, 5'd3, 1, 0, 0, 0);
    step("fl_fill1");
    chk("fl.full", in_ready, 1'b0);
    applyStimulus(1, 32'hDEAD, 3, 5'd3, 1, 0, 1, 1);
    step("fl");
    chk("fl.out_valid", out_valid, 1'b0);
    chk("fl.in_ready",  in_ready,  1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    step("fl_after");
    chk("fl.absent", out_valid, 1'b0);

`ifdef EX_MEM_PERF_EN
    // Stall counter: five stalled cycles, then flush leaves it untouched
    perf_base = perf_exp;
    applyStimulus(1, 32'h400, 4, 5'd5, 1, 0, 0, 0);
    step("perf_fill");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("perf_stall");
    chk("perf.five", perf_stall_cnt, perf_base + 5);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    step("perf_flush");
    chk("perf.after_flush", perf_stall_cnt, perf_base + 5);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
`endif

    // Randomized mixed traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    1'($urandom), ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      step("rand");
    end

    // Async reset mid-stream, observed before the next rising edge
    applyStimulus(1, 32'h500, 7, 5'd6, 1, 0, 0, 0);
    step("ar_fill0");
    step("ar_fill1");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst.out_valid", out_valid, 1'b0);
    chk("arst.in_ready",  in_ready,  1'b1);
    chk("arst.fwd_valid", fwd_valid, 1'b0);
    chk("arst.out_pc",    out_pc,    32'd0);
    model_q.delete();
`ifdef EX_MEM_PERF_EN
    perf_exp = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    checkOutput("arst_release");
    applyStimulus(1, 32'h600, 8, 5'd9, 1, 0, 1, 0);
    step("arst_resume");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    step("arst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
